uart_loader: RTL and testbench
==============================

Name: uart_loader

Overview:
- UART program-download master. Receives a framed firmware image on a dedicated RX pin and writes it word-by-word into ROM through bus master port 2.
- Stalls the core for the duration of the download. Replies with a single ACK/NAK byte on its TX pin.
- Sits upstream of the bus interconnect, in parallel with the core's instruction and data masters; enabled by the debug-enable pin.

Parameters:
- CLK_FREQ, 50000000, system clock in Hz
- BAUD, 115200, UART bit rate; BAUD_DIV = CLK_FREQ/BAUD, integer, must be >= 8
- ROM_BASE, 32'h0000_0000, byte address of the first word written
- MAX_WORDS, 4096, largest accepted word count
- TIMEOUT_BITS, 40, idle bit-times between bytes inside a frame before abort

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- en  in  1  loader enable (debug pin), level-sensitive
- rx_pin  in  1  UART RX, idle high, asynchronous to clk
- tx_pin  out  1  UART TX, idle high
- req  out  1  bus request, master 2
- we  out  1  bus write enable
- wraddr  out  32  bus byte address
- wdata  out  32  bus write data
- rdata  in  32  bus read data (unused in this revision; tie-off accepted)
- core_hold  out  1  stalls core while a frame is in progress
- busy  out  1  FSM not in IDLE
- err  out  1  sticky error flag; cleared on next valid sync byte

Behaviour:
- Reset (rst=0, async): tx_pin=1, req=0, we=0, wraddr=0, wdata=0, core_hold=0, busy=0, err=0, FSM=IDLE, all counters 0.
- RX: 2-FF synchroniser on rx_pin. Falling edge starts a byte; start bit re-checked at BAUD_DIV/2 and discarded if high. Data bits sampled at bit centres, LSB first; stop bit checked. Stop=0 is a framing error: byte dropped, err=1, FSM to IDLE, no reply.
- Frame format, all bytes: 0xA5, LEN_LO, LEN_HI, then LEN words × 4 bytes little-endian, then CSUM. CSUM = 8-bit wrap sum of all payload bytes (length bytes excluded).
- FSM states:
  - IDLE: any byte other than 0xA5 is ignored. 0xA5 -> LEN0; err cleared, core_hold=1.
  - LEN0 -> LEN1. After LEN1: LEN>MAX_WORDS -> RESP(NAK); LEN=0 -> CSUM; otherwise -> DATA.
  - DATA: assemble 4 bytes, then -> WRITE.
  - WRITE: exactly one cycle with req=1, we=1, wraddr=ROM_BASE+4*idx, wdata=assembled word. idx+1; if idx==LEN-1 -> CSUM, else -> DATA.
  - CSUM: compare received byte to running sum; match -> RESP(ACK 0x06), mismatch -> RESP(NAK 0x15) and err=1.
  - RESP: transmit the byte 8N1 at BAUD; core_hold stays 1 until the stop bit completes, then -> IDLE.
- req/we are 1 only in the WRITE cycle; wraddr/wdata hold their last value otherwise.
- Writes already performed are not rolled back on NAK.
- Timeout: in any state except IDLE/RESP, no start bit for TIMEOUT_BITS×BAUD_DIV cycles -> err=1, RESP(NAK).
- en=0 at any time: synchronous abort to IDLE next cycle; req=0, core_hold=0, tx_pin=1 (TX aborted mid-byte), err unchanged. While en=0 RX is ignored.
- Word index is 16 bits; address arithmetic wraps at 32 bits.
- Byte received while RESP is transmitting is discarded.

Test Plan:
- Bench BAUD_DIV=16. Send A5 02 00 | 11 22 33 44 | 55 66 77 88 | CSUM=0x64 -> two WRITE pulses: addr 0x0 data 0x44332211, addr 0x4 data 0x88776655. tx returns 0x06; core_hold high from sync byte to end of ACK stop bit.
- Same frame with CSUM=0x00 -> both writes occur, tx returns 0x15, err=1. A following A5 clears err.
- A5 01 20 (LEN=0x2001 > 4096) -> no req pulse, NAK 0x15.
- A5 01 00 11 22, then line idle 40 bit-times -> no write, err=1, NAK, return to IDLE.
- Drop en low mid-DATA -> busy=0 and core_hold=0 next cycle, no TX. Re-raise en; a full valid frame then succeeds.
- Byte with stop bit 0 during LEN0 -> err=1, IDLE, no reply. Async rst assertion mid-WRITE -> all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_loader
// Description : UART program-download master. Receives a framed image
//               (0xA5, LEN_LO, LEN_HI, LEN x 4 payload bytes LE, CSUM) on
//               rx_pin, writes each word to ROM through bus master 2, holds
//               the core while a frame is in progress and replies with a
//               single ACK (0x06) / NAK (0x15) byte on tx_pin.
// Ports       : clk, rst (async, active low), en (loader enable),
//               rx_pin / tx_pin (UART 8N1), req / we / wraddr / wdata /
//               rdata (bus master 2), core_hold, busy, err (sticky error).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BAUD         = 115200,
    parameter logic [31:0] ROM_BASE     = 32'h0000_0000,
    parameter int          MAX_WORDS    = 4096,
    parameter int          TIMEOUT_BITS = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        rx_pin,
    output logic        tx_pin,
    output logic        req,
    output logic        we,
    output logic [31:0] wraddr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        core_hold,
    output logic        busy,
    output logic        err
);

    localparam logic [15:0] c_div    = 16'(CLK_FREQ / BAUD);
    localparam logic [15:0] c_half   = c_div >> 1;
    localparam logic [31:0] c_to_lim = 32'(TIMEOUT_BITS * (CLK_FREQ / BAUD));
    localparam logic [31:0] c_max    = 32'(MAX_WORDS);
    localparam logic [7:0]  c_sync   = 8'hA5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_CSUM  = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    // ---------------- UART receiver ----------------
    logic        r_rx_meta, r_rx_sync, r_rx_prev;
    logic        r_rx_busy, r_rx_valid, r_rx_ferr;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        w_rx_start;

    assign w_rx_start = en & ~r_rx_busy & r_rx_prev & ~r_rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_cnt   <= 16'd0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'd0;
        end else begin
            r_rx_meta  <= rx_pin;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!en) begin
                r_rx_busy <= 1'b0;
            end else if (!r_rx_busy) begin
                if (w_rx_start) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= c_half - 16'd1;
                    r_rx_bit  <= 4'd0;
                end
            end else if (r_rx_cnt != 16'd0) begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end else begin
                r_rx_cnt <= c_div - 16'd1;
                if (r_rx_bit == 4'd0) begin
                    // Start bit gone high at its centre: treat as a glitch.
                    if (r_rx_sync) r_rx_busy <= 1'b0;
                    else           r_rx_bit  <= 4'd1;
                end else if (r_rx_bit <= 4'd8) begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                    r_rx_bit   <= r_rx_bit + 4'd1;
                end else begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_sync) r_rx_valid <= 1'b1;
                    else           r_rx_ferr  <= 1'b1;
                end
            end
        end
    end

    // ---------------- Frame FSM ----------------
    logic [2:0]  r_state, w_next;
    logic [15:0] r_len, r_idx;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_sum, r_resp;
    logic [31:0] r_asm, r_wraddr, r_wdata, r_to_cnt;
    logic        r_err;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bit;
    logic        w_nak, w_load_resp, w_set_err, w_tx_done, w_timeout, w_sync_hit;
    logic [15:0] w_len_rx;
    logic [2:0]  w_tx_idx;
    logic        w_unused_ok;

    assign w_unused_ok = ^rdata;
    assign w_len_rx    = {r_rx_shift, r_len[7:0]};
    assign w_tx_done   = (r_tx_bit == 4'd9) && (r_tx_cnt == c_div - 16'd1);
    assign w_timeout   = (r_to_cnt == c_to_lim - 32'd1);
    assign w_sync_hit  = en && (r_state == S_IDLE) && r_rx_valid && (r_rx_shift == c_sync);
    assign w_tx_idx    = 3'(r_tx_bit - 4'd1);

    always_comb begin
        w_next      = r_state;
        w_nak       = 1'b0;
        w_load_resp = 1'b0;
        w_set_err   = 1'b0;
        if (!en) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_rx_ferr)       w_set_err = 1'b1;
                    else if (w_sync_hit) w_next    = S_LEN0;
                end
                S_RESP: begin
                    if (w_tx_done) w_next = S_IDLE;
                end
                default: begin
                    if (r_rx_ferr) begin
                        w_next    = S_IDLE;
                        w_set_err = 1'b1;
                    end else if (w_timeout) begin
                        w_next      = S_RESP;
                        w_set_err   = 1'b1;
                        w_nak       = 1'b1;
                        w_load_resp = 1'b1;
                    end else begin
                        case (r_state)
                            S_LEN0: if (r_rx_valid) w_next = S_LEN1;
                            S_LEN1: begin
                                if (r_rx_valid) begin
                                    if (32'(w_len_rx) > c_max) begin
                                        w_next      = S_RESP;
                                        w_nak       = 1'b1;
                                        w_load_resp = 1'b1;
                                    end else if (w_len_rx == 16'd0) begin
                                        w_next = S_CSUM;
                                    end else begin
                                        w_next = S_DATA;
                                    end
                                end
                            end
                            S_DATA: if (r_rx_valid && r_byte_cnt == 2'd3) w_next = S_WRITE;
                            S_WRITE: w_next = (r_idx == r_len - 16'd1) ? S_CSUM : S_DATA;
                            S_CSUM: begin
                                if (r_rx_valid) begin
                                    w_next      = S_RESP;
                                    w_load_resp = 1'b1;
                                    if (r_rx_shift != r_sum) begin
                                        w_nak     = 1'b1;
                                        w_set_err = 1'b1;
                                    end
                                end
                            end
                            default: w_next = S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_len      <= 16'd0;
            r_idx      <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_sum      <= 8'd0;
            r_resp     <= 8'd0;
            r_asm      <= 32'd0;
            r_wraddr   <= 32'd0;
            r_wdata    <= 32'd0;
            r_to_cnt   <= 32'd0;
            r_err      <= 1'b0;
            r_tx_cnt   <= 16'd0;
            r_tx_bit   <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_set_err)       r_err <= 1'b1;
            else if (w_sync_hit) r_err <= 1'b0;

            if (w_sync_hit) begin
                r_idx      <= 16'd0;
                r_sum      <= 8'd0;
                r_byte_cnt <= 2'd0;
            end
            if (en && r_rx_valid && r_state == S_LEN0) r_len[7:0]  <= r_rx_shift;
            if (en && r_rx_valid && r_state == S_LEN1) r_len[15:8] <= r_rx_shift;
            if (en && r_rx_valid && r_state == S_DATA) begin
                // Shift right so the first byte lands in bits [7:0].
                r_sum      <= r_sum + r_rx_shift;
                r_asm      <= {r_rx_shift, r_asm[31:8]};
                r_byte_cnt <= r_byte_cnt + 2'd1;
                if (r_byte_cnt == 2'd3) begin
                    r_wdata  <= {r_rx_shift, r_asm[31:8]};
                    r_wraddr <= ROM_BASE + {14'd0, r_idx, 2'b00};
                end
            end
            if (r_state == S_WRITE) r_idx <= r_idx + 16'd1;

            if (w_load_resp) begin
                r_resp   <= w_nak ? 8'h15 : 8'h06;
                r_tx_cnt <= 16'd0;
                r_tx_bit <= 4'd0;
            end else if (r_state == S_RESP) begin
                if (r_tx_cnt == c_div - 16'd1) begin
                    r_tx_cnt <= 16'd0;
                    r_tx_bit <= r_tx_bit + 4'd1;
                end else begin
                    r_tx_cnt <= r_tx_cnt + 16'd1;
                end
            end

            // Inter-byte timeout restarts on every detected start bit.
            if (!en || r_state == S_IDLE || r_state == S_RESP || w_rx_start) r_to_cnt <= 32'd0;
            else                                                               r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    always_comb begin
        tx_pin = 1'b1;
        if (r_state == S_RESP) begin
            if (r_tx_bit == 4'd0)      tx_pin = 1'b0;
            else if (r_tx_bit <= 4'd8) tx_pin = r_resp[w_tx_idx];
            else                       tx_pin = 1'b1;
        end
    end

    assign req       = (r_state == S_WRITE);
    assign we        = req;
    assign wraddr    = r_wraddr;
    assign wdata     = r_wdata;
    assign busy      = (r_state != S_IDLE);
    assign core_hold = busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_loader
// Description : Directed self-checking bench for uart_loader (BAUD_DIV=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b1;
    logic        rx_pin = 1'b1;
    logic        tx_pin, req, we, core_hold, busy, err;
    logic [31:0] wraddr, wdata;
    logic [31:0] rdata = 32'd0;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  tx_q[$];
    logic        hold_q[$];
    int          we_bad = 0;

    uart_loader #(
        .CLK_FREQ(1600), .BAUD(100), .ROM_BASE(32'h0000_0000),
        .MAX_WORDS(4096), .TIMEOUT_BITS(40)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .rx_pin(rx_pin), .tx_pin(tx_pin),
        .req(req), .we(we), .wraddr(wraddr), .wdata(wdata), .rdata(rdata),
        .core_hold(core_hold), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Bus write recorder.
    always @(negedge clk) begin
        if (req) begin
            wa_q.push_back(wraddr);
            wd_q.push_back(wdata);
            if (we !== 1'b1) we_bad++;
        end
    end

    // TX byte decoder (16 clocks per bit).
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && tx_pin === 1'b0) begin
                repeat (8) @(negedge clk);
                if (tx_pin === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (16) @(negedge clk);
                        b[i] = tx_pin;
                    end
                    repeat (16) @(negedge clk);
                    tx_q.push_back(b);
                    hold_q.push_back(core_hold);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx_pin = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (16) @(negedge clk);
        end
        rx_pin = stop;
        repeat (16) @(negedge clk);
        rx_pin = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); tx_q.delete(); hold_q.delete();
    endtask

    task automatic send_good_frame(input logic [7:0] csum);
        logic [7:0] f[12] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                              8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
        f[11] = csum;
        for (int i = 0; i < 12; i++) send_byte(f[i], 1'b1);
    endtask

    task automatic test_reset();
        vectors++;
        if ({tx_pin, req, we, core_hold, busy, err} !== 6'b100000 || wraddr !== 32'd0 || wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: tx/req/we/hold/busy/err=%b addr=%h data=%h, required 100000 0 0",
                     {tx_pin, req, we, core_hold, busy, err}, wraddr, wdata);
        end
    endtask

    task automatic test_good_frame();
        clear_logs();
        vectors++;
        if (core_hold !== 1'b0) begin miscompares++; $display("FAIL hold_pre: got %b required 0", core_hold); end
        send_byte(8'hA5, 1'b1);
        vectors++;
        if (core_hold !== 1'b1) begin miscompares++; $display("FAIL hold_after_sync: got %b required 1", core_hold); end
        send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        for (int i = 0; i < 8; i++) send_byte(8'h11 * (i + 1), 1'b1);
        send_byte(8'h64, 1'b1);
        wait_idle(400);
        vectors++;
        if (wa_q.size() != 2) begin miscompares++; $display("FAIL good_nwrites: got %0d required 2", wa_q.size()); end
        else begin
            vectors++;
            if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'h44332211) begin
                miscompares++; $display("FAIL good_w0: got %h/%h required 00000000/44332211", wa_q[0], wd_q[0]);
            end
            vectors++;
            if (wa_q[1] !== 32'h4 || wd_q[1] !== 32'h88776655) begin
                miscompares++; $display("FAIL good_w1: got %h/%h required 00000004/88776655", wa_q[1], wd_q[1]);
            end
        end
        vectors++;
        if (we_bad != 0) begin miscompares++; $display("FAIL we_with_req: got %0d bad cycles required 0", we_bad); end
        vectors++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h06 || hold_q[0] !== 1'b1) begin
            miscompares++; $display("FAIL good_ack: got %0d bytes first=%h hold=%b required 1 06 1",
                                    tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, hold_q.size() ? hold_q[0] : 1'bx);
        end
        vectors++;
        if (core_hold !== 1'b0 || err !== 1'b0) begin
            miscompares++; $display("FAIL good_end: hold=%b err=%b required 0 0", core_hold, err);
        end
    endtask

    task automatic test_bad_csum();
        clear_logs();
        send_good_frame(8'h00);
        wait_idle(400);
        vectors++;
        if (wa_q.size() != 2 || tx_q.size() != 1 || tx_q[0] !== 8'h15 || err !== 1'b1) begin
            miscompares++; $display("FAIL bad_csum: writes=%0d tx=%0d byte=%h err=%b required 2 1 15 1",
                                    wa_q.size(), tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, err);
        end
        // A new sync byte clears err; then LEN=0 frame with CSUM=0 must ACK.
        clear_logs();
        send_byte(8'hA5, 1'b1);
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b required 0", err); end
        send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
        wait_idle(400);
        vectors++;
        if (wa_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            miscompares++; $display("FAIL len_zero: writes=%0d tx=%0d byte=%h required 0 1 06",
                                    wa_q.size(), tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_len_overflow();
        clear_logs();
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h20, 1'b1);
        wait_idle(400);
        vectors++;
        if (wa_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
            miscompares++; $display("FAIL len_overflow: writes=%0d tx=%0d byte=%h required 0 1 15",
                                    wa_q.size(), tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL timeout_pre: busy=%b required 1", busy); end
        wait_idle(1500);
        vectors++;
        if (wa_q.size() != 0 || tx_q.size() != 1 || tx_q[0] !== 8'h15 || err !== 1'b1) begin
            miscompares++; $display("FAIL timeout: writes=%0d tx=%0d byte=%h err=%b required 0 1 15 1",
                                    wa_q.size(), tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx, err);
        end
    endtask

    task automatic test_en_abort();
        clear_logs();
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || core_hold !== 1'b0 || tx_pin !== 1'b1 || req !== 1'b0) begin
            miscompares++; $display("FAIL en_abort: busy=%b hold=%b tx=%b req=%b required 0 0 1 0",
                                    busy, core_hold, tx_pin, req);
        end
        send_byte(8'hA5, 1'b1);   // ignored while disabled
        repeat (300) @(negedge clk);
        vectors++;
        if (tx_q.size() != 0 || wa_q.size() != 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL en_quiet: tx=%0d writes=%0d busy=%b required 0 0 0",
                                    tx_q.size(), wa_q.size(), busy);
        end
        en = 1'b1;
        repeat (4) @(negedge clk);
        send_good_frame(8'h64);
        wait_idle(400);
        vectors++;
        if (wa_q.size() != 2 || tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            miscompares++; $display("FAIL en_recover: writes=%0d tx=%0d byte=%h required 2 1 06",
                                    wa_q.size(), tx_q.size(), tx_q.size() ? tx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_frame_error();
        clear_logs();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b0);
        vectors++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            miscompares++; $display("FAIL frame_err: busy=%b err=%b required 0 1", busy, err);
        end
        repeat (300) @(negedge clk);
        vectors++;
        if (tx_q.size() != 0) begin miscompares++; $display("FAIL frame_err_reply: got %0d bytes required 0", tx_q.size()); end
    endtask

    task automatic test_reset_mid_write();
        bit hit = 1'b0;
        clear_logs();
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1);
        fork
            send_byte(8'h44, 1'b1);
            begin
                for (int i = 0; i < 400 && !hit; i++) begin
                    @(negedge clk);
                    if (req === 1'b1) hit = 1'b1;
                end
                if (hit) begin
                    #2 rst = 1'b0;
                    #1;
                    vectors++;
                    if ({tx_pin, req, we, core_hold, busy, err} !== 6'b100000 || wraddr !== 32'd0 || wdata !== 32'd0) begin
                        miscompares++;
                        $display("FAIL rst_mid_write: tx/req/we/hold/busy/err=%b addr=%h data=%h, required 100000 0 0",
                                 {tx_pin, req, we, core_hold, busy, err}, wraddr, wdata);
                    end
                end
            end
        join
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rst_mid_write_req: req seen=%b required 1", hit); end
        @(negedge clk) rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1;
        test_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        test_good_frame();
        test_bad_csum();
        test_len_overflow();
        test_timeout();
        test_en_abort();
        test_frame_error();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
